leaderboard_sequencer: RTL and testbench

Sequencing controller for the `leaderboard` ranking block. It takes finished run times from the stopwatch and commits each one to the leaderboard through a defined drive/sample window. It then reads back the rank achieved, schedules the rank announcement tone, and drives the leaderboard display selection for both automatic post-run display and user browsing. A one-deep pending buffer absorbs a run that finishes while a previous one is still being announced.

---
 rtl/leaderboard_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_leaderboard_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/leaderboard_sequencer.sv
// Sequencer that commits finished stopwatch runs to the leaderboard, reads back
// the achieved rank, announces it with a tone, then shows the new entry.
module leaderboard_sequencer #(
  parameter int TIME_W       = 39,
  parameter int TONE_CYCLES  = 50_000_000,
  parameter int DWELL_CYCLES = 200_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_done,
  input  logic [TIME_W-1:0] run_time,
  input  logic [1:0]        run_mode,
  input  logic              browse_btn,
  input  logic              board_btn,
  input  logic [2:0]        lb_sound,
  output logic [TIME_W-1:0] lb_time,
  output logic [1:0]        lb_mode,
  output logic [2:0]        lb_display,
  output logic              view_board,
  output logic              tone_en,
  output logic [1:0]        tone_rank,
  output logic              busy,
  output logic              overrun,
  output logic [2:0]        o_dbg_state,
  output logic              o_dbg_pend_valid
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COMMIT   = 3'd1,
    S_SAMPLE   = 3'd2,
    S_ANNOUNCE = 3'd3,
    S_SHOW     = 3'd4
  } state_t;

  localparam int MAX_CYC = (TONE_CYCLES > DWELL_CYCLES) ? TONE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] TONE_LOAD  = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_mode;
  logic [1:0]          r_rank;
  logic                r_pend_valid;
  logic [TIME_W-1:0]   r_pend_time;
  logic [1:0]          r_pend_mode;
  logic [TIME_W-1:0]   r_lb_time;
  logic [1:0]          r_lb_mode;
  logic [2:0]          r_lb_display;
  logic                r_view_board;
  logic                r_tone_en;
  logic [1:0]          r_tone_rank;
  logic                r_busy;
  logic                r_overrun;

  logic                w_run_valid;
  logic                w_to_pend;
  logic [1:0]          w_rank;
  logic [2:0]          w_browse_next;

  // run_done is a one-cycle strobe with no back-pressure; a ranked run is
  // either started directly from IDLE or parked in the one-deep pending slot.
  assign w_run_valid = run_done & (run_mode[0] ^ run_mode[1]);
  assign w_to_pend   = w_run_valid & ((r_state != S_IDLE) | r_pend_valid);

  always_comb begin
    w_rank = 2'd0;
    if (lb_sound[0])      w_rank = 2'd1;
    else if (lb_sound[1]) w_rank = 2'd2;
    else if (lb_sound[2]) w_rank = 2'd3;
  end

  always_comb begin
    case (r_lb_display)
      3'b000:  w_browse_next = 3'b100;
      3'b100:  w_browse_next = 3'b101;
      3'b101:  w_browse_next = 3'b110;
      default: w_browse_next = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mode       <= 2'b00;
      r_rank       <= 2'b00;
      r_pend_valid <= 1'b0;
      r_pend_time  <= '0;
      r_pend_mode  <= 2'b00;
      r_lb_time    <= '0;
      r_lb_mode    <= 2'b00;
      r_lb_display <= 3'b000;
      r_view_board <= 1'b0;
      r_tone_en    <= 1'b0;
      r_tone_rank  <= 2'b00;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // A new run arriving as IDLE drains the slot simply replaces it.
      if (w_to_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_time  <= run_time;
        r_pend_mode  <= run_mode;
        if (r_pend_valid && r_state != S_IDLE) r_overrun <= 1'b1;
      end else if (r_state == S_IDLE && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_lb_mode <= 2'b00;
          if (r_pend_valid) begin
            r_lb_time <= r_pend_time;
            r_lb_mode <= r_pend_mode;
            r_mode    <= r_pend_mode;
            r_busy    <= 1'b1;
            r_state   <= S_COMMIT;
          end else if (w_run_valid) begin
            r_lb_time <= run_time;
            r_lb_mode <= run_mode;
            r_mode    <= run_mode;
            r_busy    <= 1'b1;
            r_state   <= S_COMMIT;
          end else begin
            if (browse_btn) r_lb_display <= w_browse_next;
            if (board_btn)  r_view_board <= ~r_view_board;
          end
        end
        S_COMMIT: r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_lb_mode <= 2'b00;
          if (w_rank != 2'd0) begin
            r_rank      <= w_rank;
            r_tone_en   <= 1'b1;
            r_tone_rank <= w_rank;
            r_cnt       <= TONE_LOAD;
            r_state     <= S_ANNOUNCE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ANNOUNCE: begin
          if (r_cnt == '0) begin
            r_tone_en    <= 1'b0;
            r_tone_rank  <= 2'b00;
            r_lb_display <= {1'b1, r_rank - 2'd1};
            r_view_board <= r_mode[1];
            r_cnt        <= DWELL_LOAD;
            r_state      <= S_SHOW;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt == '0) begin
            r_lb_display <= 3'b000;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lb_time          = r_lb_time;
  assign lb_mode          = r_lb_mode;
  assign lb_display       = r_lb_display;
  assign view_board       = r_view_board;
  assign tone_en          = r_tone_en;
  assign tone_rank        = r_tone_rank;
  assign busy             = r_busy;
  assign overrun          = r_overrun;
  assign o_dbg_state      = r_state;
  assign o_dbg_pend_valid = r_pend_valid;

endmodule

// File: tb/tb_leaderboard_sequencer.sv
// Directed bench for leaderboard_sequencer with short tone/dwell lengths.
module tb_leaderboard_sequencer;

  localparam int TIME_W = 39;
  localparam int TONE   = 4;
  localparam int DWELL  = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COMMIT = 3'd1;

  logic              clk = 1'b0;
  logic              reset;
  logic              run_done;
  logic [TIME_W-1:0] run_time;
  logic [1:0]        run_mode;
  logic              browse_btn;
  logic              board_btn;
  logic [2:0]        lb_sound;
  logic [TIME_W-1:0] lb_time;
  logic [1:0]        lb_mode;
  logic [2:0]        lb_display;
  logic              view_board;
  logic              tone_en;
  logic [1:0]        tone_rank;
  logic              busy;
  logic              overrun;
  logic [2:0]        dbg_state;
  logic              dbg_pend_valid;

  int checks   = 0;
  int failures = 0;

  leaderboard_sequencer #(
    .TIME_W(TIME_W), .TONE_CYCLES(TONE), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .run_done(run_done), .run_time(run_time),
    .run_mode(run_mode), .browse_btn(browse_btn), .board_btn(board_btn),
    .lb_sound(lb_sound), .lb_time(lb_time), .lb_mode(lb_mode),
    .lb_display(lb_display), .view_board(view_board), .tone_en(tone_en),
    .tone_rank(tone_rank), .busy(busy), .overrun(overrun),
    .o_dbg_state(dbg_state), .o_dbg_pend_valid(dbg_pend_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one run_done pulse through the next edge
  task automatic pulse_run(input logic [TIME_W-1:0] t, input logic [1:0] m);
    run_time = t;
    run_mode = m;
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
  endtask

  // full ranked run: commit, sample, tone, show, back to idle
  task automatic ranked_run(input logic [TIME_W-1:0] t, input logic [1:0] m,
                            input logic [2:0] snd, input logic [1:0] rank,
                            input logic [2:0] disp, input logic vb);
    lb_sound = snd;
    pulse_run(t, m);
    check_val("commit_time", lb_time, t);
    check_val("commit_mode", lb_mode, m);
    check_val("commit_busy", busy, 1);
    tick();
    check_val("sample_mode", lb_mode, m);
    check_val("sample_tone", tone_en, 0);
    tick();
    check_val("ann_mode_clr", lb_mode, 0);
    for (int i = 0; i < TONE; i++) begin
      check_val("ann_tone", tone_en, 1);
      check_val("ann_rank", tone_rank, rank);
      tick();
    end
    for (int i = 0; i < DWELL; i++) begin
      check_val("show_tone", tone_en, 0);
      check_val("show_rank", tone_rank, 0);
      check_val("show_disp", lb_display, disp);
      check_val("show_vb", view_board, vb);
      check_val("show_busy", busy, 1);
      tick();
    end
    check_val("end_disp", lb_display, 0);
    check_val("end_busy", busy, 0);
    check_val("end_state", dbg_state, ST_IDLE);
  endtask

  initial begin
    logic [2:0] exp_disp [4];
    exp_disp[0] = 3'b100; exp_disp[1] = 3'b101;
    exp_disp[2] = 3'b110; exp_disp[3] = 3'b000;

    reset = 1'b1; run_done = 1'b0; run_time = '0; run_mode = 2'b00;
    browse_btn = 1'b0; board_btn = 1'b0; lb_sound = 3'b000;
    tick(2);
    reset = 1'b0;
    check_val("rst_time", lb_time, 0);
    check_val("rst_mode", lb_mode, 0);
    check_val("rst_disp", lb_display, 0);
    check_val("rst_vb", view_board, 0);
    check_val("rst_tone", tone_en, 0);
    check_val("rst_rank", tone_rank, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovr", overrun, 0);
    check_val("rst_state", dbg_state, ST_IDLE);

    // rank 1 on fast board, rank 2 on slow board
    ranked_run(39'd143000, 2'b01, 3'b001, 2'd1, 3'b100, 1'b0);
    ranked_run(39'd139000, 2'b10, 3'b010, 2'd2, 3'b101, 1'b1);

    // multi-hot sound: lowest bit wins -> rank 2
    ranked_run(39'd141000, 2'b10, 3'b110, 2'd2, 3'b101, 1'b1);

    // unranked commit returns to IDLE three cycles after the pulse
    lb_sound = 3'b000;
    pulse_run(39'd200000, 2'b01);
    tick();
    tick();
    check_val("unr_busy", busy, 0);
    check_val("unr_state", dbg_state, ST_IDLE);
    check_val("unr_tone", tone_en, 0);
    check_val("unr_disp", lb_display, 0);
    check_val("unr_time_hold", lb_time, 39'd200000);

    // mode 00 / 11 pulses in IDLE are ignored
    pulse_run(39'd55, 2'b00);
    check_val("m00_busy", busy, 0);
    pulse_run(39'd66, 2'b11);
    check_val("m11_busy", busy, 0);
    check_val("m11_time", lb_time, 39'd200000);

    // two runs during ANNOUNCE: second overwrites the first and sets overrun
    lb_sound = 3'b100;
    pulse_run(39'd100000, 2'b01);
    tick(2);
    check_val("ovr_ann", tone_en, 1);
    pulse_run(39'd142000, 2'b01);
    check_val("ovr_pend1", dbg_pend_valid, 1);
    check_val("ovr_flag0", overrun, 0);
    pulse_run(39'd150000, 2'b10);
    check_val("ovr_flag1", overrun, 1);
    check_val("ovr_rank3", tone_rank, 2'd3);
    tick(2);
    check_val("ovr_show_disp", lb_display, 3'b110);
    check_val("ovr_show_vb", view_board, 0);
    lb_sound = 3'b000;
    tick(DWELL);
    check_val("ovr_idle_busy", busy, 0);
    check_val("ovr_idle_disp", lb_display, 0);
    tick();
    check_val("ovr_commit_st", dbg_state, ST_COMMIT);
    check_val("ovr_commit_time", lb_time, 39'd150000);
    check_val("ovr_commit_mode", lb_mode, 2'b10);
    check_val("ovr_pend_clr", dbg_pend_valid, 0);
    tick(2);
    check_val("ovr_back_idle", busy, 0);
    check_val("ovr_sticky", overrun, 1);

    // browsing in IDLE
    for (int i = 0; i < 4; i++) begin
      browse_btn = 1'b1;
      tick();
      browse_btn = 1'b0;
      check_val("browse", lb_display, exp_disp[i]);
    end
    board_btn = 1'b1;
    tick();
    board_btn = 1'b0;
    check_val("board_tog", view_board, 1);

    // buttons ignored while busy; then reset during ANNOUNCE with a pending run
    lb_sound = 3'b001;
    pulse_run(39'd160000, 2'b01);
    tick(2);
    browse_btn = 1'b1; board_btn = 1'b1;
    tick();
    browse_btn = 1'b0; board_btn = 1'b0;
    check_val("busy_disp", lb_display, 0);
    check_val("busy_vb", view_board, 1);
    pulse_run(39'd170000, 2'b10);
    check_val("pre_rst_pend", dbg_pend_valid, 1);
    check_val("pre_rst_tone", tone_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_tone", tone_en, 0);
    check_val("mid_rst_state", dbg_state, ST_IDLE);
    check_val("mid_rst_pend", dbg_pend_valid, 0);
    check_val("mid_rst_ovr", overrun, 0);
    check_val("mid_rst_time", lb_time, 0);
    check_val("mid_rst_vb", view_board, 0);
    pulse_run(39'd180000, 2'b11);
    check_val("post_rst_m11", busy, 0);
    tick();
    check_val("post_rst_idle", dbg_state, ST_IDLE);

    // run departing IDLE wins over a same-cycle button press
    lb_sound = 3'b000;
    browse_btn = 1'b1; board_btn = 1'b1;
    pulse_run(39'd190000, 2'b01);
    browse_btn = 1'b0; board_btn = 1'b0;
    check_val("win_state", dbg_state, ST_COMMIT);
    check_val("win_disp", lb_display, 0);
    check_val("win_vb", view_board, 0);
    tick(2);
    check_val("win_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
